sin_sweep_initiator: RTL

SIN_SWEEP_INITIATOR -- requirements
Module: sin_sweep_initiator

---
 rtl/sin_sweep_initiator_pkg.sv | 30 +++
 rtl/res_fifo.sv | 57 +++++
 rtl/sin_sweep_initiator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sin_sweep_initiator_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sin_sweep_initiator_pkg : shared types/constants for sine sweeps |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sin_sweep_initiator_pkg;

  localparam int FRAC_BITS          = 8;
  localparam int ANGLE_W            = 2 * FRAC_BITS;  // Q8.8 angle / result
  localparam int INDEX_W            = 8;
  localparam int TOL_W              = 8;
  localparam int RES_W              = ANGLE_W + INDEX_W + 1;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ANGLE_W-1:0] data;
    logic [INDEX_W-1:0] index;
    logic               last;
  } res_t;

endpackage
`default_nettype wire

// File: rtl/res_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | res_fifo : synchronous FIFO, power-of-2 depth, occupancy output  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign count  = r_count;
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  // Head is masked while empty so the output reads zero after reset.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/sin_sweep_initiator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sin_sweep_initiator : issues a sweep of angles to a sine core    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sin_sweep_initiator
  import sin_sweep_initiator_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_x0,
  input  logic [15:0] cmd_step,
  input  logic [7:0]  cmd_count,
  input  logic [7:0]  cmd_tol,
  output logic [15:0] core_x,
  output logic [7:0]  core_y,
  output logic        core_start,
  input  logic        core_ready,
  input  logic [15:0] core_sinx,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [7:0]  res_index,
  output logic        res_last,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ANGLE_W-1:0]   r_angle;
  logic [ANGLE_W-1:0]   r_step;
  logic [ANGLE_W-1:0]   r_sinx;
  logic [INDEX_W-1:0]   r_count;
  logic [INDEX_W-1:0]   r_index;
  logic [TOL_W-1:0]     r_tol;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic                 r_timeout_err;

  logic                 w_cmd_fire;
  logic                 w_start;
  logic                 w_push;
  logic                 w_timeout;
  res_t                 w_push_word;
  res_t                 w_head;
  logic [RES_W-1:0]     w_head_bits;
  logic [CNT_W-1:0]     w_fifo_count;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_fire  = 1'b0;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cmd_fire = 1'b1;
          if (cmd_count != '0) w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Only one request is ever outstanding, so a free slot now guarantees
        // room for its result at STORE.
        if (!w_fifo_full) begin
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_ready) begin
          w_state_nxt = ST_STORE;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STORE: begin
        w_push      = 1'b1;
        w_state_nxt = (({1'b0, r_index} + 9'd1) < {1'b0, r_count}) ? ST_ISSUE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_angle       <= '0;
      r_step        <= '0;
      r_sinx        <= '0;
      r_count       <= '0;
      r_index       <= '0;
      r_tol         <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_fire) begin
        r_angle       <= cmd_x0;
        r_step        <= cmd_step;
        r_count       <= cmd_count;
        r_tol         <= cmd_tol;
        r_index       <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_start)                r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_state == ST_WAIT && core_ready) r_sinx <= core_sinx;
      if (w_push) begin
        r_angle <= r_angle + r_step;
        r_index <= r_index + 1'b1;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_push_word = '{data: r_sinx, index: r_index, last: (r_index == r_count - 8'd1)};

  res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_push_word),
    .rd_en   (res_ready),
    .rd_data (w_head_bits),
    .count   (w_fifo_count),
    .empty   (w_fifo_empty),
    .full    (w_fifo_full)
  );

  assign w_head      = res_t'(w_head_bits);
  assign cmd_ready   = (r_state == ST_IDLE);
  assign core_start  = w_start;
  assign core_x      = r_angle;
  assign core_y      = r_tol;
  assign res_valid   = !w_fifo_empty;
  assign res_data    = w_head.data;
  assign res_index   = w_head.index;
  assign res_last    = w_head.last;
  assign busy        = (r_state != ST_IDLE) || (w_fifo_count != '0);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
